// File: rtl/ethpipe_rx_slots_if.sv
// Frame-RAM write bus and descriptor handshake of the GMII receive engine.
// master: the receive engine (drives RAM writes and descriptors, takes desc_ready)
// slave : the consumer side (RAM / DMA), drives desc_ready
//   ram_wr_en, ram_addr {slot, word}, ram_data (byte k in lane k%4), ram_byte_en
//   desc_valid / desc_ready handshake with desc_slot, desc_len, desc_ts, desc_err
interface ethpipe_rx_slots_if #(
  parameter int SLOT_W  = 2,
  parameter int SLOT_AW = 9,
  parameter int LEN_W   = 12,
  parameter int TS_W    = 64
);
  logic                       ram_wr_en;
  logic [SLOT_W+SLOT_AW-1:0]  ram_addr;
  logic [31:0]                ram_data;
  logic [3:0]                 ram_byte_en;
  logic                       desc_valid;
  logic                       desc_ready;
  logic [SLOT_W-1:0]          desc_slot;
  logic [LEN_W-1:0]           desc_len;
  logic [TS_W-1:0]            desc_ts;
  logic                       desc_err;

  modport master (
    output ram_wr_en, ram_addr, ram_data, ram_byte_en,
    output desc_valid, desc_slot, desc_len, desc_ts, desc_err,
    input  desc_ready
  );

  modport slave (
    input  ram_wr_en, ram_addr, ram_data, ram_byte_en,
    input  desc_valid, desc_slot, desc_len, desc_ts, desc_err,
    output desc_ready
  );
endinterface

// File: rtl/ethpipe_rx_slots.sv
// GMII receive engine writing frames into a ring of SLOT_NUM slots of a
// shared 32-bit frame RAM. Preamble/SFD are stripped, bytes are packed
// little-endian into words, and one descriptor (slot, length, SFD timestamp,
// error) is posted per stored frame. Single clock domain (gmii_rx_clk).
// Ports:
//   gmii_rx_clk, sys_rst_n          clock, async active-low reset
//   global_counter                  time base sampled on the SFD cycle
//   gmii_rxd, gmii_rx_dv, gmii_rx_er GMII receive side
//   bus (master)                    frame RAM writes + descriptor handshake
//   slot_release                    pulse: frees the oldest occupied slot
//   free_cnt                        number of free slots
//   drop_cnt                        saturating count of frames dropped at SFD
//
// state     | meaning
// WAIT_IDLE | after reset, wait for dv low so no frame is entered mid-way
// IDLE      | line idle, waiting for dv
// PREAMBLE  | skipping 0x55 bytes, waiting for SFD 0xD5
// DATA      | storing frame bytes into the current slot
// DONE      | post descriptor, advance write slot
// DROP      | discard remainder of frame until dv low
module ethpipe_rx_slots #(
  parameter int SLOT_NUM = 4,
  parameter int SLOT_AW  = 9,
  parameter int LEN_W    = 12,
  parameter int TS_W     = 64,
  parameter int MAX_LEN  = 1522
) (
  input  logic                        gmii_rx_clk,
  input  logic                        sys_rst_n,
  input  logic [TS_W-1:0]             global_counter,
  input  logic [7:0]                  gmii_rxd,
  input  logic                        gmii_rx_dv,
  input  logic                        gmii_rx_er,
  ethpipe_rx_slots_if.master          bus,
  input  logic                        slot_release,
  output logic [$clog2(SLOT_NUM):0]   free_cnt,
  output logic [15:0]                 drop_cnt
);
  localparam int SLOT_W = $clog2(SLOT_NUM);
  localparam logic [LEN_W-1:0]  MAX_LEN_C  = LEN_W'(MAX_LEN);
  localparam logic [SLOT_W:0]   SLOT_NUM_C = (SLOT_W+1)'(SLOT_NUM);

  typedef enum logic [2:0] {
    WAIT_IDLE, IDLE, PREAMBLE, DATA, DONE, DROP
  } state_t;

  state_t state_q, state_d;
  logic   sfd_accept, sfd_reject;

  logic [LEN_W-1:0]          cnt_q;
  logic                      err_q;
  logic [23:0]               lane_q;
  logic [TS_W-1:0]           ts_q;
  logic [SLOT_W-1:0]         wr_slot_q;
  logic [SLOT_W:0]           free_q;
  logic [15:0]               drop_q;

  logic                      ram_wr_q;
  logic [SLOT_W+SLOT_AW-1:0] ram_addr_q;
  logic [31:0]               ram_data_q;
  logic [3:0]                ram_be_q;

  logic                      desc_valid_q;
  logic [SLOT_W-1:0]         desc_slot_q;
  logic [LEN_W-1:0]          desc_len_q;
  logic [TS_W-1:0]           desc_ts_q;
  logic                      desc_err_q;

  logic [3:0]                flush_be;
  logic [31:0]               flush_data;
  logic                      done, rel_ok;

  assign bus.ram_wr_en   = ram_wr_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_data    = ram_data_q;
  assign bus.ram_byte_en = ram_be_q;
  assign bus.desc_valid  = desc_valid_q;
  assign bus.desc_slot   = desc_slot_q;
  assign bus.desc_len    = desc_len_q;
  assign bus.desc_ts     = desc_ts_q;
  assign bus.desc_err    = desc_err_q;
  assign free_cnt        = free_q;
  assign drop_cnt        = drop_q;

  // The oldest occupied slot is wr_slot - (SLOT_NUM - free_cnt), so the
  // release order needs no pointer of its own; only the count is kept.
  assign done   = (state_q == DONE);
  assign rel_ok = slot_release && (free_q != SLOT_NUM_C);

  always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= WAIT_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    sfd_accept = 1'b0;
    sfd_reject = 1'b0;
    case (state_q)
      WAIT_IDLE: if (!gmii_rx_dv) state_d = IDLE;
      IDLE:      if (gmii_rx_dv) state_d = PREAMBLE;
      PREAMBLE: begin
        if (!gmii_rx_dv) begin
          state_d = IDLE;
        end else if (gmii_rxd == 8'hD5) begin
          // a pending unaccepted descriptor would be overwritten by this frame
          if (free_q != '0 && !(desc_valid_q && !bus.desc_ready)) begin
            state_d    = DATA;
            sfd_accept = 1'b1;
          end else begin
            state_d    = DROP;
            sfd_reject = 1'b1;
          end
        end else if (gmii_rxd != 8'h55) begin
          state_d = DROP;
        end
      end
      DATA:      if (!gmii_rx_dv) state_d = (cnt_q == '0) ? IDLE : DONE;
      DONE:      state_d = IDLE;
      DROP:      if (!gmii_rx_dv) state_d = IDLE;
      default:   state_d = WAIT_IDLE;
    endcase
  end

  // partial final word: enable only the lanes that hold frame bytes
  always_comb begin
    flush_be   = 4'b0000;
    flush_data = 32'h0;
    case (cnt_q[1:0])
      2'd1: begin flush_be = 4'b0001; flush_data = {24'h0, lane_q[7:0]};  end
      2'd2: begin flush_be = 4'b0011; flush_data = {16'h0, lane_q[15:0]}; end
      2'd3: begin flush_be = 4'b0111; flush_data = {8'h0,  lane_q};       end
      default: ;
    endcase
  end

  always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q        <= '0;
      err_q        <= 1'b0;
      lane_q       <= '0;
      ts_q         <= '0;
      wr_slot_q    <= '0;
      free_q       <= SLOT_NUM_C;
      drop_q       <= '0;
      ram_wr_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      ram_be_q     <= '0;
      desc_valid_q <= 1'b0;
      desc_slot_q  <= '0;
      desc_len_q   <= '0;
      desc_ts_q    <= '0;
      desc_err_q   <= 1'b0;
    end else begin
      ram_wr_q <= 1'b0;
      ram_be_q <= 4'b0000;

      if (sfd_accept) begin
        cnt_q <= '0;
        err_q <= 1'b0;
        ts_q  <= global_counter;
      end

      if (sfd_reject && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;

      if (state_q == DATA) begin
        if (gmii_rx_dv) begin
          if (gmii_rx_er) err_q <= 1'b1;
          if (cnt_q == MAX_LEN_C) begin
            // truncated: byte discarded, length frozen
            err_q <= 1'b1;
          end else begin
            case (cnt_q[1:0])
              2'd0: lane_q[7:0]   <= gmii_rxd;
              2'd1: lane_q[15:8]  <= gmii_rxd;
              2'd2: lane_q[23:16] <= gmii_rxd;
              default: begin
                ram_wr_q   <= 1'b1;
                ram_be_q   <= 4'hF;
                ram_addr_q <= {wr_slot_q, cnt_q[SLOT_AW+1:2]};
                ram_data_q <= {gmii_rxd, lane_q};
              end
            endcase
            cnt_q <= cnt_q + LEN_W'(1);
          end
        end else if (cnt_q[1:0] != 2'd0) begin
          ram_wr_q   <= 1'b1;
          ram_be_q   <= flush_be;
          ram_addr_q <= {wr_slot_q, cnt_q[SLOT_AW+1:2]};
          ram_data_q <= flush_data;
        end
      end

      if (done) begin
        desc_valid_q <= 1'b1;
        desc_slot_q  <= wr_slot_q;
        desc_len_q   <= cnt_q;
        desc_ts_q    <= ts_q;
        desc_err_q   <= err_q;
        wr_slot_q    <= wr_slot_q + SLOT_W'(1);
      end else if (desc_valid_q && bus.desc_ready) begin
        desc_valid_q <= 1'b0;
      end

      case ({rel_ok, done})
        2'b10:   free_q <= free_q + (SLOT_W+1)'(1);
        2'b01:   free_q <= free_q - (SLOT_W+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ethpipe_rx_slots.sv
module tb_ethpipe_rx_slots;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] gc = 64'd1000;
  logic [7:0]  rxd = 8'h00;
  logic        dv = 1'b0;
  logic        er = 1'b0;
  logic        rel = 1'b0;
  logic [2:0]  free_cnt;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  ethpipe_rx_slots_if #(.SLOT_W(2), .SLOT_AW(9), .LEN_W(12), .TS_W(64)) bus();

  ethpipe_rx_slots dut (
    .gmii_rx_clk   (clk),
    .sys_rst_n     (rst_n),
    .global_counter(gc),
    .gmii_rxd      (rxd),
    .gmii_rx_dv    (dv),
    .gmii_rx_er    (er),
    .bus           (bus),
    .slot_release  (rel),
    .free_cnt      (free_cnt),
    .drop_cnt      (drop_cnt)
  );

  always #4 clk = ~clk;
  always @(posedge clk) gc <= gc + 64'd1;

  logic [10:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [3:0]  wb_q[$];
  logic [1:0]  ds_q[$];
  logic [11:0] dl_q[$];
  logic [63:0] dt_q[$];
  logic        de_q[$];

  always @(negedge clk) begin
    if (rst_n && bus.ram_wr_en) begin
      wa_q.push_back(bus.ram_addr);
      wd_q.push_back(bus.ram_data);
      wb_q.push_back(bus.ram_byte_en);
    end
    if (rst_n && bus.desc_valid && bus.desc_ready) begin
      ds_q.push_back(bus.desc_slot);
      dl_q.push_back(bus.desc_len);
      dt_q.push_back(bus.desc_ts);
      de_q.push_back(bus.desc_err);
    end
  end

  function automatic logic [7:0] pat(input int i);
    logic [31:0] v;
    v = i * 7 + 3;
    return v[7:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wa_q.delete(); wd_q.delete(); wb_q.delete();
    ds_q.delete(); dl_q.delete(); dt_q.delete(); de_q.delete();
  endtask

  task automatic apply_reset();
    step();
    rst_n = 1'b0; dv = 1'b0; er = 1'b0; rxd = 8'h00; rel = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();
    clear_logs();
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic e);
    step();
    dv = 1'b1; rxd = b; er = e;
  endtask

  // ends with dv low driven; the next edge is the dv=0 sample
  task automatic send_frame(input int n, input int er_at, output logic [63:0] ts);
    for (int i = 0; i < 7; i++) drive_byte(8'h55, 1'b0);
    drive_byte(8'hD5, 1'b0);
    ts = gc;
    for (int i = 0; i < n; i++) drive_byte(pat(i), (i == er_at));
    step();
    dv = 1'b0; rxd = 8'h00; er = 1'b0;
  endtask

  task automatic release_pulse();
    step(); rel = 1'b1;
    step(); rel = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.desc_ready = 1'b0;
    repeat (3) step();
    checks++;
    if (free_cnt !== 3'd4) begin errors++; $display("FAIL rst_free got %0d exp 4", free_cnt); end
    checks++;
    if ({bus.ram_wr_en, bus.ram_addr, bus.ram_data, bus.ram_byte_en} !== '0) begin
      errors++; $display("FAIL rst_ram got wr=%0b addr=%0h data=%0h be=%0h exp all 0",
                         bus.ram_wr_en, bus.ram_addr, bus.ram_data, bus.ram_byte_en);
    end
    checks++;
    if ({bus.desc_valid, bus.desc_slot, bus.desc_len, bus.desc_ts, bus.desc_err, drop_cnt} !== '0) begin
      errors++; $display("FAIL rst_desc got v=%0b len=%0d ts=%0h drop=%0d exp all 0",
                         bus.desc_valid, bus.desc_len, bus.desc_ts, drop_cnt);
    end
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_full_words();
    logic [63:0] ts;
    logic [31:0] exp;
    clear_logs();
    bus.desc_ready = 1'b1;
    send_frame(64, -1, ts);
    step();
    checks++;
    if (bus.desc_valid !== 1'b0) begin errors++; $display("FAIL t64_valid_early got %0b exp 0", bus.desc_valid); end
    step();
    checks++;
    if (bus.desc_valid !== 1'b1) begin errors++; $display("FAIL t64_valid_n2 got %0b exp 1", bus.desc_valid); end
    repeat (10) step();
    checks++;
    if (wa_q.size() !== 16) begin errors++; $display("FAIL t64_nwrites got %0d exp 16", wa_q.size()); end
    else begin
      for (int w = 0; w < 16; w++) begin
        exp = {pat(4*w+3), pat(4*w+2), pat(4*w+1), pat(4*w)};
        checks++;
        if (wa_q[w] !== 11'(w) || wb_q[w] !== 4'hF || wd_q[w] !== exp) begin
          errors++; $display("FAIL t64_word%0d got a=%0h be=%0h d=%0h exp a=%0h be=f d=%0h",
                             w, wa_q[w], wb_q[w], wd_q[w], w, exp);
        end
      end
    end
    checks++;
    if (dl_q.size() !== 1) begin errors++; $display("FAIL t64_ndesc got %0d exp 1", dl_q.size()); end
    else begin
      checks++;
      if (ds_q[0] !== 2'd0 || dl_q[0] !== 12'd64 || de_q[0] !== 1'b0 || dt_q[0] !== ts) begin
        errors++; $display("FAIL t64_desc got slot=%0d len=%0d err=%0b ts=%0d exp 0 64 0 %0d",
                           ds_q[0], dl_q[0], de_q[0], dt_q[0], ts);
      end
    end
    checks++;
    if (free_cnt !== 3'd3) begin errors++; $display("FAIL t64_free got %0d exp 3", free_cnt); end
    checks++;
    if (bus.desc_valid !== 1'b0) begin errors++; $display("FAIL t64_valid_fall got %0b exp 0", bus.desc_valid); end
  endtask

  task automatic test_partial_word();
    logic [63:0] ts;
    logic [31:0] d;
    clear_logs();
    send_frame(61, -1, ts);
    repeat (12) step();
    checks++;
    if (wa_q.size() !== 16) begin errors++; $display("FAIL t61_nwrites got %0d exp 16", wa_q.size()); end
    else begin
      d = wd_q[15];
      checks++;
      if (wa_q[15] !== 11'h20F || wb_q[15] !== 4'b0001 || d[7:0] !== pat(60)) begin
        errors++; $display("FAIL t61_last got a=%0h be=%0h d=%0h exp a=20f be=1 lane0=%0h",
                           wa_q[15], wb_q[15], d, pat(60));
      end
      checks++;
      if (wb_q[14] !== 4'hF || wa_q[0] !== 11'h200) begin
        errors++; $display("FAIL t61_full got be14=%0h a0=%0h exp f 200", wb_q[14], wa_q[0]);
      end
    end
    checks++;
    if (dl_q.size() !== 1) begin errors++; $display("FAIL t61_ndesc got %0d exp 1", dl_q.size()); end
    else begin
      checks++;
      if (ds_q[0] !== 2'd1 || dl_q[0] !== 12'd61 || dt_q[0] !== ts || de_q[0] !== 1'b0) begin
        errors++; $display("FAIL t61_desc got slot=%0d len=%0d ts=%0d err=%0b exp 1 61 %0d 0",
                           ds_q[0], dl_q[0], dt_q[0], de_q[0], ts);
      end
    end
    checks++;
    if (free_cnt !== 3'd2) begin errors++; $display("FAIL t61_free got %0d exp 2", free_cnt); end
    release_pulse();
    checks++;
    if (free_cnt !== 3'd3) begin errors++; $display("FAIL rel1_free got %0d exp 3", free_cnt); end
    release_pulse();
    release_pulse();
    checks++;
    if (free_cnt !== 3'd4) begin errors++; $display("FAIL rel_full_ignored got %0d exp 4", free_cnt); end
  endtask

  task automatic test_slot_ring();
    logic [63:0] ts;
    apply_reset();
    bus.desc_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      send_frame(20, -1, ts);
      repeat (12) step();
    end
    checks++;
    if (ds_q.size() !== 4) begin errors++; $display("FAIL ring_ndesc got %0d exp 4", ds_q.size()); end
    else begin
      for (int f = 0; f < 4; f++) begin
        checks++;
        if (ds_q[f] !== 2'(f)) begin errors++; $display("FAIL ring_slot%0d got %0d exp %0d", f, ds_q[f], f); end
      end
    end
    checks++;
    if (free_cnt !== 3'd0) begin errors++; $display("FAIL ring_free_full got %0d exp 0", free_cnt); end
    wa_q.delete();
    send_frame(20, -1, ts);
    repeat (12) step();
    checks++;
    if (drop_cnt !== 16'd1 || wa_q.size() !== 0 || ds_q.size() !== 4) begin
      errors++; $display("FAIL ring_drop got drop=%0d writes=%0d ndesc=%0d exp 1 0 4",
                         drop_cnt, wa_q.size(), ds_q.size());
    end
    release_pulse();
    checks++;
    if (free_cnt !== 3'd1) begin errors++; $display("FAIL ring_rel got %0d exp 1", free_cnt); end
    send_frame(20, -1, ts);
    repeat (12) step();
    checks++;
    if (ds_q.size() !== 5) begin errors++; $display("FAIL ring_f6_ndesc got %0d exp 5", ds_q.size()); end
    else begin
      checks++;
      if (ds_q[4] !== 2'd0) begin errors++; $display("FAIL ring_f6_slot got %0d exp 0", ds_q[4]); end
    end
    checks++;
    if (free_cnt !== 3'd0) begin errors++; $display("FAIL ring_f6_free got %0d exp 0", free_cnt); end
  endtask

  task automatic test_trunc_err();
    logic [63:0] ts;
    logic [31:0] d;
    int bad;
    apply_reset();
    bus.desc_ready = 1'b1;
    send_frame(2000, -1, ts);
    repeat (12) step();
    checks++;
    if (dl_q.size() !== 1) begin errors++; $display("FAIL trunc_ndesc got %0d exp 1", dl_q.size()); end
    else begin
      checks++;
      if (dl_q[0] !== 12'd1522 || de_q[0] !== 1'b1 || ds_q[0] !== 2'd0) begin
        errors++; $display("FAIL trunc_desc got len=%0d err=%0b slot=%0d exp 1522 1 0", dl_q[0], de_q[0], ds_q[0]);
      end
    end
    checks++;
    if (wa_q.size() !== 381) begin errors++; $display("FAIL trunc_nwrites got %0d exp 381", wa_q.size()); end
    else begin
      bad = 0;
      foreach (wa_q[i]) if (wa_q[i] > 11'd380) bad++;
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL trunc_addr_over got %0d exp 0", bad); end
      d = wd_q[380];
      checks++;
      if (wa_q[380] !== 11'd380 || wb_q[380] !== 4'b0011 || d[15:0] !== {pat(1521), pat(1520)}) begin
        errors++; $display("FAIL trunc_last got a=%0d be=%0h d=%0h exp 380 3 %0h",
                           wa_q[380], wb_q[380], d, {pat(1521), pat(1520)});
      end
    end
    clear_logs();
    send_frame(100, 50, ts);
    repeat (12) step();
    checks++;
    if (dl_q.size() !== 1) begin errors++; $display("FAIL rxer_ndesc got %0d exp 1", dl_q.size()); end
    else begin
      checks++;
      if (dl_q[0] !== 12'd100 || de_q[0] !== 1'b1 || ds_q[0] !== 2'd1) begin
        errors++; $display("FAIL rxer_desc got len=%0d err=%0b slot=%0d exp 100 1 1", dl_q[0], de_q[0], ds_q[0]);
      end
    end
    clear_logs();
    drive_byte(8'h55, 1'b0);
    drive_byte(8'h55, 1'b0);
    drive_byte(8'h12, 1'b0);
    drive_byte(8'hD5, 1'b0);
    for (int i = 0; i < 10; i++) drive_byte(pat(i), 1'b0);
    step(); dv = 1'b0;
    repeat (12) step();
    checks++;
    if (drop_cnt !== 16'd0 || ds_q.size() !== 0 || wa_q.size() !== 0 || free_cnt !== 3'd2) begin
      errors++; $display("FAIL badpre got drop=%0d ndesc=%0d writes=%0d free=%0d exp 0 0 0 2",
                         drop_cnt, ds_q.size(), wa_q.size(), free_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] ts;
    apply_reset();
    bus.desc_ready = 1'b1;
    for (int i = 0; i < 7; i++) drive_byte(8'h55, 1'b0);
    drive_byte(8'hD5, 1'b0);
    for (int i = 0; i < 30; i++) drive_byte(pat(i), 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.ram_wr_en !== 1'b0 || bus.ram_byte_en !== 4'h0 || bus.desc_valid !== 1'b0 || free_cnt !== 3'd4) begin
      errors++; $display("FAIL midrst_async got wr=%0b be=%0h v=%0b free=%0d exp 0 0 0 4",
                         bus.ram_wr_en, bus.ram_byte_en, bus.desc_valid, free_cnt);
    end
    drive_byte(pat(31), 1'b0);
    drive_byte(pat(32), 1'b0);
    rst_n = 1'b1;
    clear_logs();
    drive_byte(8'h55, 1'b0);
    drive_byte(8'h55, 1'b0);
    drive_byte(8'hD5, 1'b0);
    for (int i = 0; i < 16; i++) drive_byte(pat(i), 1'b0);
    step(); dv = 1'b0;
    repeat (12) step();
    checks++;
    if (wa_q.size() !== 0 || ds_q.size() !== 0 || drop_cnt !== 16'd0) begin
      errors++; $display("FAIL midrst_ignore got writes=%0d ndesc=%0d drop=%0d exp 0 0 0",
                         wa_q.size(), ds_q.size(), drop_cnt);
    end
    send_frame(20, -1, ts);
    repeat (12) step();
    checks++;
    if (ds_q.size() !== 1 || wa_q.size() !== 5) begin
      errors++; $display("FAIL midrst_next got ndesc=%0d writes=%0d exp 1 5", ds_q.size(), wa_q.size());
    end else begin
      checks++;
      if (ds_q[0] !== 2'd0 || dl_q[0] !== 12'd20 || wa_q[0] !== 11'd0) begin
        errors++; $display("FAIL midrst_slot got slot=%0d len=%0d a0=%0h exp 0 20 0", ds_q[0], dl_q[0], wa_q[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] ts1, ts2, ts3;
    apply_reset();
    bus.desc_ready = 1'b0;
    send_frame(40, -1, ts1);
    repeat (12) step();
    checks++;
    if (bus.desc_valid !== 1'b1 || bus.desc_slot !== 2'd0 || bus.desc_len !== 12'd40 || bus.desc_ts !== ts1) begin
      errors++; $display("FAIL bp_f1 got v=%0b slot=%0d len=%0d ts=%0d exp 1 0 40 %0d",
                         bus.desc_valid, bus.desc_slot, bus.desc_len, bus.desc_ts, ts1);
    end
    wa_q.delete();
    send_frame(30, -1, ts2);
    repeat (12) step();
    checks++;
    if (drop_cnt !== 16'd1 || wa_q.size() !== 0 || free_cnt !== 3'd3) begin
      errors++; $display("FAIL bp_drop got drop=%0d writes=%0d free=%0d exp 1 0 3", drop_cnt, wa_q.size(), free_cnt);
    end
    checks++;
    if (bus.desc_valid !== 1'b1 || bus.desc_len !== 12'd40 || bus.desc_ts !== ts1 || bus.desc_slot !== 2'd0) begin
      errors++; $display("FAIL bp_hold got v=%0b len=%0d ts=%0d slot=%0d exp 1 40 %0d 0",
                         bus.desc_valid, bus.desc_len, bus.desc_ts, bus.desc_slot, ts1);
    end
    bus.desc_ready = 1'b1;
    step();
    step();
    checks++;
    if (bus.desc_valid !== 1'b0 || dl_q.size() !== 1) begin
      errors++; $display("FAIL bp_accept got v=%0b naccepted=%0d exp 0 1", bus.desc_valid, dl_q.size());
    end
    send_frame(20, -1, ts3);
    step();
    rel = 1'b1;
    step();
    rel = 1'b0;
    checks++;
    if (free_cnt !== 3'd3) begin errors++; $display("FAIL bp_rel_done got %0d exp 3", free_cnt); end
    repeat (12) step();
    checks++;
    if (dl_q.size() !== 2) begin errors++; $display("FAIL bp_f3_ndesc got %0d exp 2", dl_q.size()); end
    else begin
      checks++;
      if (ds_q[1] !== 2'd1 || dl_q[1] !== 12'd20 || dt_q[1] !== ts3) begin
        errors++; $display("FAIL bp_f3_desc got slot=%0d len=%0d ts=%0d exp 1 20 %0d", ds_q[1], dl_q[1], dt_q[1], ts3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_words();
    test_partial_word();
    test_slot_ring();
    test_trunc_err();
    test_reset_mid();
    test_backpressure();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
